// File: rtl/pipe_register.sv
// Elastic multi-stage pipeline register with valid/ready handshake, bubble
// collapsing, flush, global enable and an occupancy count.
module pipe_register #(
  parameter int N     = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       clr,
  input  logic                       en,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [N-1:0]               d,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [N-1:0]               q,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);

  localparam int OW = $clog2(DEPTH+1);

  logic [N-1:0]     r [DEPTH];
  logic [DEPTH-1:0] v;
  logic [DEPTH-1:0] rdy;
  logic             acc;

  function automatic logic [OW-1:0] popcount(input logic [DEPTH-1:0] bits);
    logic [OW-1:0] c;
    c = '0;
    for (int i = 0; i < DEPTH; i++) c = c + OW'(bits[i]);
    return c;
  endfunction

  // A stage may load when any stage at or beyond it is empty, or the sink drains.
  always_comb begin
    acc = out_ready;
    rdy = '0;
    for (int i = DEPTH-1; i >= 0; i--) begin
      acc    = acc | !v[i];
      rdy[i] = acc;
    end
  end

  assign in_ready  = en & !flush & !clr & rdy[0];
  assign out_valid = en & v[DEPTH-1];
  assign q         = r[DEPTH-1];
  assign occupancy = popcount(v);

  always_ff @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < DEPTH; i++) r[i] <= '0;
      v <= '0;
    end else if (flush) begin
      v <= '0;
    end else if (en) begin
      if (rdy[0]) begin
        r[0] <= d;
        v[0] <= in_valid;
      end
      for (int i = 1; i < DEPTH; i++) begin
        if (rdy[i]) begin
          r[i] <= r[i-1];
          v[i] <= v[i-1];
        end
      end
    end
  end

endmodule

// File: tb/tb_pipe_register.sv
// Bench for pipe_register: a 4-deep 8-bit instance and a 1-deep 1-bit instance,
// each checked every cycle against a queue-level model, plus literal pins.
module tb_pipe_register;

  localparam int DA = 4;

  logic       clk = 1'b0;
  logic       clr, en, flush;
  logic       in_valid, out_ready, in_ready, out_valid;
  logic [7:0] d, q;
  logic [2:0] occupancy;
  logic       in_valid1, out_ready1, in_ready1, out_valid1;
  logic [0:0] d1, q1;
  logic [0:0] occupancy1;

  int checks = 0;
  int fails  = 0;

  pipe_register #(.N(8), .DEPTH(DA)) dut_a (
    .clk(clk), .clr(clr), .en(en), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .d(d),
    .out_valid(out_valid), .out_ready(out_ready), .q(q), .occupancy(occupancy)
  );

  pipe_register #(.N(1), .DEPTH(1)) dut_b (
    .clk(clk), .clr(clr), .en(en), .flush(flush),
    .in_valid(in_valid1), .in_ready(in_ready1), .d(d1),
    .out_valid(out_valid1), .out_ready(out_ready1), .q(q1), .occupancy(occupancy1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Model A: words oldest-first with their stage position.
  int         mpos[$];
  logic [7:0] mdat[$];
  int         sz;
  bit         ov, ir, left;
  // Model B: a single-entry buffer.
  bit         full1, ov1, ir1;
  logic [0:0] dat1;

  always @(negedge clk) begin
    sz = mdat.size();
    ov = en && sz > 0 && mpos[0] == DA-1;
    ir = en && !flush && !clr && (out_ready || sz < DA);
    chk("a_in_ready", 32'(in_ready), 32'(ir));
    chk("a_out_valid", 32'(out_valid), 32'(ov));
    chk("a_occupancy", 32'(occupancy), 32'(sz));
    if (ov) chk("a_q", 32'(q), 32'(mdat[0]));
    if (clr || flush) begin
      mpos.delete();
      mdat.delete();
    end else if (en) begin
      left = 0;
      for (int k = 0; k < mpos.size(); k++) begin
        // k words lie ahead; a word moves if the sink drains or a gap exists ahead.
        if (out_ready || k < DA-1-mpos[k]) begin
          if (mpos[k] == DA-1) left = 1;
          else mpos[k] = mpos[k] + 1;
        end
      end
      if (left) begin
        void'(mpos.pop_front());
        void'(mdat.pop_front());
      end
      if (ir && in_valid) begin
        mpos.push_back(0);
        mdat.push_back(d);
      end
    end

    ov1 = en && full1;
    ir1 = en && !flush && !clr && (!full1 || out_ready1);
    chk("b_in_ready", 32'(in_ready1), 32'(ir1));
    chk("b_out_valid", 32'(out_valid1), 32'(ov1));
    chk("b_occupancy", 32'(occupancy1), 32'(full1));
    if (ov1) chk("b_q", 32'(q1), 32'(dat1));
    if (clr || flush) full1 = 0;
    else if (en) begin
      if (ov1 && out_ready1) full1 = 0;
      if (ir1 && in_valid1) begin
        full1 = 1;
        dat1  = d1;
      end
    end
  end

  int         peak;
  logic [7:0] qs;
  int         mode;

  initial begin
    full1 = 0; dat1 = '0;
    clr = 1; en = 1; flush = 0; in_valid = 1; d = 8'hAA; out_ready = 0;
    in_valid1 = 0; d1 = '0; out_ready1 = 0;

    // Reset held two cycles with a word offered.
    step(); step();
    chk("rst_q", 32'(q), 32'h00);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_occupancy", 32'(occupancy), 0);
    chk("rst_in_ready", 32'(in_ready), 0);
    clr = 0; in_valid = 0;
    #1;
    chk("post_rst_in_ready", 32'(in_ready), 1);
    chk("post_rst_occupancy", 32'(occupancy), 0);

    // Streaming 0x01..0x08 with the sink always ready.
    out_ready = 1; peak = 0;
    for (int i = 0; i < 12; i++) begin
      in_valid = (i < 8);
      d = 8'(i + 1);
      step();
      if (int'(occupancy) > peak) peak = int'(occupancy);
      if (i == 2) chk("stream_not_yet", 32'(out_valid), 0);
      if (i >= 3 && i <= 10) begin
        chk("stream_valid", 32'(out_valid), 1);
        chk("stream_q", 32'(q), 32'(i - 2));
      end
    end
    chk("stream_peak", 32'(peak), 4);
    chk("stream_empty", 32'(occupancy), 0);

    // Backpressure: four fill the pipe, the fifth waits for the sink.
    out_ready = 0; in_valid = 1;
    for (int i = 0; i < 4; i++) begin
      d = 8'(8'h31 + i);
      step();
    end
    d = 8'h35;
    #1;
    chk("bp_full_in_ready", 32'(in_ready), 0);
    chk("bp_full_occ", 32'(occupancy), 4);
    out_ready = 1;
    #1;
    chk("bp_pass_in_ready", 32'(in_ready), 1);
    chk("bp_first_q", 32'(q), 32'h31);
    step();
    chk("bp_occ_kept", 32'(occupancy), 4);
    in_valid = 0;
    for (int j = 0; j < 4; j++) begin
      chk("bp_order_valid", 32'(out_valid), 1);
      chk("bp_order_q", 32'(q), 32'(8'h32 + j));
      step();
    end
    chk("bp_drained", 32'(occupancy), 0);

    // Bubble collapse with the sink stalled.
    out_ready = 0; in_valid = 1; d = 8'h11; step();
    in_valid = 0; step(); step();
    in_valid = 1; d = 8'h22; step();
    in_valid = 0; step(); step(); step();
    chk("bub_occ", 32'(occupancy), 2);
    chk("bub_in_ready", 32'(in_ready), 1);
    chk("bub_q", 32'(q), 32'h11);
    chk("bub_stages", 32'(dut_a.v), 32'b1100);
    out_ready = 1; step(); step();

    // Stall with en low, then flush while a word is offered.
    out_ready = 0; in_valid = 1;
    for (int i = 0; i < 4; i++) begin
      d = 8'(8'h41 + i);
      step();
    end
    en = 0; d = 8'h45; out_ready = 1;
    #1;
    qs = q;
    chk("stall_q_head", 32'(qs), 32'h41);
    for (int i = 0; i < 3; i++) begin
      chk("stall_out_valid", 32'(out_valid), 0);
      chk("stall_in_ready", 32'(in_ready), 0);
      step();
      chk("stall_q", 32'(q), 32'(qs));
      chk("stall_occ", 32'(occupancy), 4);
    end
    en = 1; flush = 1; d = 8'h55;
    #1;
    chk("flush_in_ready", 32'(in_ready), 0);
    step();
    flush = 0; in_valid = 0;
    #1;
    chk("flush_occ", 32'(occupancy), 0);
    for (int i = 0; i < 5; i++) begin
      chk("flush_no_out", 32'(out_valid), 0);
      step();
    end

    // Single-entry instance.
    in_valid1 = 1; d1 = 1'b1; out_ready1 = 0; step();
    chk("b_lat_valid", 32'(out_valid1), 1);
    chk("b_lat_q", 32'(q1), 1);
    chk("b_full_in_ready", 32'(in_ready1), 0);
    out_ready1 = 1; d1 = 1'b0;
    #1;
    chk("b_pass_in_ready", 32'(in_ready1), 1);
    step();
    chk("b_pass_q", 32'(q1), 0);
    chk("b_pass_occ", 32'(occupancy1), 1);
    for (int i = 0; i < 6; i++) begin
      d1 = 1'(i);
      step();
    end
    in_valid1 = 0; step(); step();

    // Randomized traffic for both instances.
    for (int c = 0; c < 3000; c++) begin
      mode = (c / 500) % 3;
      en         = ($urandom % 10) != 0;
      flush      = ($urandom % 60) == 0;
      clr        = ($urandom % 250) == 0;
      in_valid   = ($urandom % 4) != 0;
      d          = 8'($urandom);
      out_ready  = (mode == 0) ? (($urandom % 4) == 0) :
                   (mode == 1) ? (($urandom % 2) == 0) : (($urandom % 10) != 0);
      in_valid1  = ($urandom % 2) != 0;
      d1         = 1'($urandom);
      out_ready1 = ($urandom % 3) != 0;
      step();
    end
    clr = 0; flush = 0; en = 1; in_valid = 0; in_valid1 = 0;
    step(); step();

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
